// File: rtl/ysyx_23060025_axi_arbiter_pkg.sv
// rtl/ysyx_23060025_axi_arbiter_pkg.sv - grant encodings and AXI response codes for the IFU/LSU arbiter
package ysyx_23060025_axi_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam logic [1:0] ARB_IDLE  = 2'b00;
  localparam logic [1:0] ARB_M0_RD = 2'b01;
  localparam logic [1:0] ARB_M1_RD = 2'b10;
  localparam logic [1:0] ARB_M1_WR = 2'b11;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_23060025_axi_arbiter_if.sv
// rtl/ysyx_23060025_axi_arbiter_if.sv - single-beat AXI4-Lite channel bundle with master/slave views
interface ysyx_23060025_axi_arbiter_if #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
);
  logic [ADDR_LEN-1:0]   ar_addr;
  logic [2:0]            ar_size;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [DATA_LEN-1:0]   r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;
  logic [ADDR_LEN-1:0]   aw_addr;
  logic [2:0]            aw_size;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [DATA_LEN-1:0]   w_data;
  logic [DATA_LEN/8-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;

  // Side that issues requests (IFU/LSU, or the arbiter towards memory).
  modport master (
    output ar_addr, ar_size, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready,
    output aw_addr, aw_size, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready
  );

  // Side that answers requests (memory, or the arbiter towards IFU/LSU).
  modport slave (
    input ar_addr, ar_size, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready,
    input aw_addr, aw_size, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready
  );
endinterface

// File: rtl/ysyx_23060025_arb_pick.sv
// rtl/ysyx_23060025_arb_pick.sv - next-grant policy; ARB_ROUND_ROBIN_EN swaps fixed priority for M0/M1 alternation
module ysyx_23060025_arb_pick
  import ysyx_23060025_axi_arbiter_pkg::*;
(
  input  logic       i_r0,
  input  logic       i_r1r,
  input  logic       i_r1w,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       i_last_grant,
`endif
  output arb_state_t o_next
);

  arb_state_t w_m1_state;

  // Within M1 a read always beats a write; M1 beats M0 unless round robin overrides.
  always_comb begin
    w_m1_state = i_r1r ? ARB_M1_RD : ARB_M1_WR;
    o_next     = ARB_IDLE;
    if (i_r1r || i_r1w) begin
      o_next = w_m1_state;
    end else if (i_r0) begin
      o_next = ARB_M0_RD;
    end
`ifdef ARB_ROUND_ROBIN_EN
    if (i_r0 && (i_r1r || i_r1w) && i_last_grant) begin
      o_next = ARB_M0_RD;
    end
`endif
  end

endmodule

// File: rtl/ysyx_23060025_axi_arbiter.sv
// rtl/ysyx_23060025_axi_arbiter.sv - two-master (IFU/LSU) to one-slave AXI4-Lite arbiter, ARB_ROUND_ROBIN_EN optional
module ysyx_23060025_axi_arbiter
  import ysyx_23060025_axi_arbiter_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  ysyx_23060025_axi_arbiter_if.slave        m0,
  ysyx_23060025_axi_arbiter_if.slave        m1,
  ysyx_23060025_axi_arbiter_if.master       s,
  output logic [1:0]                        grant_o
);

  arb_state_t          r_state;
  logic                r_addr_done;
  logic                r_data_done;
  arb_state_t          w_next;
  logic                w_ar_hs;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_r_hs;
  logic                w_b_hs;
  logic                w_rd_exit;
  logic                w_wr_exit;
  logic [ADDR_LEN-1:0] w_rd_addr;
  logic [DATA_LEN-1:0] w_r_data;
  logic                w_unused_m0;

  // M0 is the instruction fetch port and never writes.
  assign w_unused_m0 = ^{m0.aw_addr, m0.aw_size, m0.aw_valid,
                         m0.w_data, m0.w_strb, m0.w_valid, m0.b_ready};

  assign w_ar_hs   = s.ar_valid & s.ar_ready;
  assign w_aw_hs   = s.aw_valid & s.aw_ready;
  assign w_w_hs    = s.w_valid & s.w_ready;
  assign w_r_hs    = s.r_valid & s.r_ready;
  assign w_b_hs    = s.b_valid & s.b_ready;
  assign w_rd_exit = ((r_state == ARB_M0_RD) || (r_state == ARB_M1_RD)) && w_r_hs;
  assign w_wr_exit = (r_state == ARB_M1_WR) && w_b_hs;
  assign w_rd_addr = (r_state == ARB_M0_RD) ? m0.ar_addr : m1.ar_addr;
  assign w_r_data  = s.r_data;
  assign grant_o   = r_state;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // Remember which master finished last so a tie goes to the other one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_rd_exit && (r_state == ARB_M0_RD)) begin
      r_last_grant <= 1'b0;
    end else if (w_rd_exit || w_wr_exit) begin
      r_last_grant <= 1'b1;
    end
  end

  ysyx_23060025_arb_pick u_pick (
    .i_r0         (m0.ar_valid),
    .i_r1r        (m1.ar_valid),
    .i_r1w        (m1.aw_valid | m1.w_valid),
    .i_last_grant (r_last_grant),
    .o_next       (w_next)
  );
`else
  ysyx_23060025_arb_pick u_pick (
    .i_r0   (m0.ar_valid),
    .i_r1r  (m1.ar_valid),
    .i_r1w  (m1.aw_valid | m1.w_valid),
    .o_next (w_next)
  );
`endif

  // Grant FSM: arbitrate in IDLE, hold the grant until the response handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_addr_done <= 1'b0;
      r_data_done <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_state     <= w_next;
          r_addr_done <= 1'b0;
          r_data_done <= 1'b0;
        end
        ARB_M0_RD, ARB_M1_RD: begin
          if (w_ar_hs) r_addr_done <= 1'b1;
          if (w_rd_exit) r_state <= ARB_IDLE;
        end
        default: begin
          if (w_aw_hs) r_addr_done <= 1'b1;
          if (w_w_hs) r_data_done <= 1'b1;
          if (w_wr_exit) r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Route the granted master to the slave; everything else is held at zero.
  always_comb begin
    s.ar_addr   = '0;
    s.ar_size   = '0;
    s.ar_valid  = 1'b0;
    s.r_ready   = 1'b0;
    s.aw_addr   = '0;
    s.aw_size   = '0;
    s.aw_valid  = 1'b0;
    s.w_data    = '0;
    s.w_strb    = '0;
    s.w_valid   = 1'b0;
    s.b_ready   = 1'b0;
    m0.ar_ready = 1'b0;
    m0.r_data   = '0;
    m0.r_resp   = '0;
    m0.r_valid  = 1'b0;
    m0.aw_ready = 1'b0;
    m0.w_ready  = 1'b0;
    m0.b_resp   = '0;
    m0.b_valid  = 1'b0;
    m1.ar_ready = 1'b0;
    m1.r_data   = '0;
    m1.r_resp   = '0;
    m1.r_valid  = 1'b0;
    m1.aw_ready = 1'b0;
    m1.w_ready  = 1'b0;
    m1.b_resp   = '0;
    m1.b_valid  = 1'b0;
    case (r_state)
      ARB_M0_RD: begin
        if (!r_addr_done) begin
          s.ar_addr   = w_rd_addr;
          s.ar_size   = m0.ar_size;
          s.ar_valid  = m0.ar_valid;
          m0.ar_ready = s.ar_ready;
        end
        m0.r_data  = w_r_data;
        m0.r_resp  = s.r_resp;
        m0.r_valid = s.r_valid;
        s.r_ready  = m0.r_ready;
      end
      ARB_M1_RD: begin
        if (!r_addr_done) begin
          s.ar_addr   = w_rd_addr;
          s.ar_size   = m1.ar_size;
          s.ar_valid  = m1.ar_valid;
          m1.ar_ready = s.ar_ready;
        end
        m1.r_data  = w_r_data;
        m1.r_resp  = s.r_resp;
        m1.r_valid = s.r_valid;
        s.r_ready  = m1.r_ready;
      end
      ARB_M1_WR: begin
        if (!r_addr_done) begin
          s.aw_addr   = m1.aw_addr;
          s.aw_size   = m1.aw_size;
          s.aw_valid  = m1.aw_valid;
          m1.aw_ready = s.aw_ready;
        end
        if (!r_data_done) begin
          s.w_data   = m1.w_data;
          s.w_strb   = m1.w_strb;
          s.w_valid  = m1.w_valid;
          m1.w_ready = s.w_ready;
        end
        m1.b_resp  = s.b_resp;
        m1.b_valid = s.b_valid;
        s.b_ready  = m1.b_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter.sv
// tb/tb_ysyx_23060025_axi_arbiter.sv - directed vector bench for the IFU/LSU AXI4-Lite arbiter
module tb_ysyx_23060025_axi_arbiter;
  import ysyx_23060025_axi_arbiter_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant_o;
  int         n_checks = 0;
  int         n_errors = 0;

  ysyx_23060025_axi_arbiter_if #(.DATA_LEN(32), .ADDR_LEN(32)) m0_if ();
  ysyx_23060025_axi_arbiter_if #(.DATA_LEN(32), .ADDR_LEN(32)) m1_if ();
  ysyx_23060025_axi_arbiter_if #(.DATA_LEN(32), .ADDR_LEN(32)) s_if ();

  ysyx_23060025_axi_arbiter #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .grant_o (grant_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        m0_arv;
    logic        m1_arv;
    logic        m1_awv;
    logic        m1_wv;
    logic [1:0]  grant;
    logic        s_arv;
    logic        s_awv;
    logic        s_wv;
    logic [31:0] s_araddr;
  } vec_t;

  vec_t vecs[9];

  localparam logic [31:0] M0_ADDR = 32'h8000_0000;
  localparam logic [31:0] M1_RADDR = 32'h1000_0000;
  localparam logic [31:0] M1_WADDR = 32'h0F00_0002;

  function automatic vec_t mk(logic a, logic b, logic c, logic d, logic [1:0] g,
                              logic e, logic f, logic h, logic [31:0] ad);
    vec_t v;
    v.m0_arv = a; v.m1_arv = b; v.m1_awv = c; v.m1_wv = d; v.grant = g;
    v.s_arv = e; v.s_awv = f; v.s_wv = h; v.s_araddr = ad;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.ar_addr = M0_ADDR; m0_if.ar_size = 3'd2; m0_if.ar_valid = 1'b0; m0_if.r_ready = 1'b0;
    m0_if.aw_addr = '0; m0_if.aw_size = '0; m0_if.aw_valid = 1'b0;
    m0_if.w_data = '0; m0_if.w_strb = '0; m0_if.w_valid = 1'b0; m0_if.b_ready = 1'b0;
    m1_if.ar_addr = M1_RADDR; m1_if.ar_size = 3'd2; m1_if.ar_valid = 1'b0; m1_if.r_ready = 1'b0;
    m1_if.aw_addr = M1_WADDR; m1_if.aw_size = 3'd0; m1_if.aw_valid = 1'b0;
    m1_if.w_data = 32'h00AB_0000; m1_if.w_strb = 4'b0100; m1_if.w_valid = 1'b0; m1_if.b_ready = 1'b0;
    s_if.ar_ready = 1'b0; s_if.r_data = '0; s_if.r_resp = '0; s_if.r_valid = 1'b0;
    s_if.aw_ready = 1'b0; s_if.w_ready = 1'b0; s_if.b_resp = '0; s_if.b_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = mk(0, 0, 0, 0, ARB_IDLE,  0, 0, 0, 32'h0);
    vecs[1] = mk(1, 0, 0, 0, ARB_M0_RD, 1, 0, 0, M0_ADDR);
    vecs[2] = mk(0, 1, 0, 0, ARB_M1_RD, 1, 0, 0, M1_RADDR);
    vecs[3] = mk(0, 0, 1, 0, ARB_M1_WR, 0, 1, 0, 32'h0);
    vecs[4] = mk(0, 0, 0, 1, ARB_M1_WR, 0, 0, 1, 32'h0);
    vecs[7] = mk(0, 1, 1, 1, ARB_M1_RD, 1, 0, 0, M1_RADDR);
`ifdef ARB_ROUND_ROBIN_EN
    vecs[5] = mk(1, 1, 0, 0, ARB_M0_RD, 1, 0, 0, M0_ADDR);
    vecs[6] = mk(1, 0, 1, 1, ARB_M0_RD, 1, 0, 0, M0_ADDR);
    vecs[8] = mk(1, 1, 1, 1, ARB_M0_RD, 1, 0, 0, M0_ADDR);
`else
    vecs[5] = mk(1, 1, 0, 0, ARB_M1_RD, 1, 0, 0, M1_RADDR);
    vecs[6] = mk(1, 0, 1, 1, ARB_M1_WR, 0, 1, 1, 32'h0);
    vecs[8] = mk(1, 1, 1, 1, ARB_M1_RD, 1, 0, 0, M1_RADDR);
`endif

    do_reset();
    step();
    chk("reset_grant", grant_o, ARB_IDLE);
    chk("reset_s_ar_valid", s_if.ar_valid, 0);
    chk("reset_s_r_ready", s_if.r_ready, 0);

    // Arbitration table: request pattern in IDLE, grant one cycle later.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      m0_if.ar_valid = vecs[i].m0_arv;
      m1_if.ar_valid = vecs[i].m1_arv;
      m1_if.aw_valid = vecs[i].m1_awv;
      m1_if.w_valid  = vecs[i].m1_wv;
      #1;
      chk($sformatf("v%0d_idle_s_ar_valid", i), s_if.ar_valid, 0);
      chk($sformatf("v%0d_idle_s_aw_valid", i), s_if.aw_valid, 0);
      step();
      chk($sformatf("v%0d_grant", i), grant_o, vecs[i].grant);
      chk($sformatf("v%0d_s_ar_valid", i), s_if.ar_valid, vecs[i].s_arv);
      chk($sformatf("v%0d_s_aw_valid", i), s_if.aw_valid, vecs[i].s_awv);
      chk($sformatf("v%0d_s_w_valid", i), s_if.w_valid, vecs[i].s_wv);
      chk($sformatf("v%0d_s_ar_addr", i), s_if.ar_addr, vecs[i].s_araddr);
    end

    // M0 read with a slow address handshake.
    do_reset();
    m0_if.ar_valid = 1'b1;
    step();
    chk("a_grant", grant_o, ARB_M0_RD);
    chk("a_m1_ar_ready", m1_if.ar_ready, 0);
    step();
    step();
    s_if.ar_ready = 1'b1;
    #1;
    chk("a_m0_ar_ready", m0_if.ar_ready, 1);
    step();
    s_if.ar_ready = 1'b0;
    m0_if.ar_valid = 1'b0;
    s_if.r_valid = 1'b1; s_if.r_data = 32'h0000_0413; s_if.r_resp = AXI_RESP_OKAY;
    m0_if.r_ready = 1'b1;
    #1;
    chk("a_s_ar_valid_after_hs", s_if.ar_valid, 0);
    chk("a_m0_r_valid", m0_if.r_valid, 1);
    chk("a_m0_r_data", m0_if.r_data, 32'h0000_0413);
    chk("a_m1_r_valid", m1_if.r_valid, 0);
    chk("a_s_r_ready", s_if.r_ready, 1);
    step();
    chk("a_exit_grant", grant_o, ARB_IDLE);
    clear_inputs();

`ifndef ARB_ROUND_ROBIN_EN
    // Simultaneous reads: M1 first, M0 held and served after one idle cycle.
    do_reset();
    m0_if.ar_valid = 1'b1;
    m1_if.ar_valid = 1'b1;
    step();
    s_if.ar_ready = 1'b1;
    #1;
    chk("b_grant_m1", grant_o, ARB_M1_RD);
    chk("b_s_ar_addr", s_if.ar_addr, M1_RADDR);
    chk("b_m1_ar_ready", m1_if.ar_ready, 1);
    chk("b_m0_ar_ready", m0_if.ar_ready, 0);
    step();
    m1_if.ar_valid = 1'b0;
    s_if.ar_ready = 1'b0;
    s_if.r_valid = 1'b1; s_if.r_data = 32'hDEAD_BEEF; m1_if.r_ready = 1'b1;
    #1;
    chk("b_m1_r_data", m1_if.r_data, 32'hDEAD_BEEF);
    chk("b_m0_r_valid", m0_if.r_valid, 0);
    step();
    s_if.r_valid = 1'b0;
    #1;
    chk("b_idle_gap", grant_o, ARB_IDLE);
    chk("b_idle_m0_ar_ready", m0_if.ar_ready, 0);
    step();
    chk("b_grant_m0", grant_o, ARB_M0_RD);
    chk("b_s_ar_addr_m0", s_if.ar_addr, M0_ADDR);
    clear_inputs();
`endif

    // M1 write with AW and W accepted in different cycles; valids held by the master.
    do_reset();
    m1_if.aw_valid = 1'b1;
    m1_if.w_valid = 1'b1;
    step();
    chk("c_grant", grant_o, ARB_M1_WR);
    chk("c_s_w_strb", s_if.w_strb, 4'b0100);
    chk("c_s_aw_addr", s_if.aw_addr, M1_WADDR);
    step();
    s_if.aw_ready = 1'b1;
    #1;
    chk("c_m1_aw_ready", m1_if.aw_ready, 1);
    step();
    #1;
    chk("c_s_aw_valid_dropped", s_if.aw_valid, 0);
    chk("c_m1_aw_ready_dropped", m1_if.aw_ready, 0);
    chk("c_s_w_valid_held", s_if.w_valid, 1);
    step();
    s_if.w_ready = 1'b1;
    #1;
    chk("c_m1_w_ready", m1_if.w_ready, 1);
    step();
    chk("c_s_w_valid_dropped", s_if.w_valid, 0);
    m1_if.aw_valid = 1'b0; m1_if.w_valid = 1'b0;
    s_if.aw_ready = 1'b0; s_if.w_ready = 1'b0;
    s_if.b_valid = 1'b1; s_if.b_resp = AXI_RESP_OKAY; m1_if.b_ready = 1'b1;
    #1;
    chk("c_m1_b_valid", m1_if.b_valid, 1);
    chk("c_m1_b_resp", m1_if.b_resp, AXI_RESP_OKAY);
    chk("c_s_b_ready", s_if.b_ready, 1);
    step();
    chk("c_exit_grant", grant_o, ARB_IDLE);
    clear_inputs();

    // DECERR on an M0 read, response in the same cycle as the address handshake.
    do_reset();
    m0_if.ar_valid = 1'b1;
    step();
    s_if.ar_ready = 1'b1;
    s_if.r_valid = 1'b1; s_if.r_resp = AXI_RESP_DECERR; s_if.r_data = 32'h1;
    m0_if.r_ready = 1'b1;
    #1;
    chk("d_m0_r_resp", m0_if.r_resp, AXI_RESP_DECERR);
    chk("d_m0_r_valid", m0_if.r_valid, 1);
    step();
    chk("d_exit_grant", grant_o, ARB_IDLE);
    clear_inputs();

    // Reset after AW accepted: late B response must not be forwarded.
    do_reset();
    m1_if.aw_valid = 1'b1; m1_if.w_valid = 1'b1;
    step();
    s_if.aw_ready = 1'b1;
    step();
    m1_if.aw_valid = 1'b0; m1_if.w_valid = 1'b0; s_if.aw_ready = 1'b0;
    m1_if.b_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("e_grant", grant_o, ARB_IDLE);
    chk("e_s_w_valid", s_if.w_valid, 0);
    chk("e_m1_w_ready", m1_if.w_ready, 0);
    s_if.b_valid = 1'b1;
    #1;
    chk("e_m1_b_valid", m1_if.b_valid, 0);
    chk("e_s_b_ready", s_if.b_ready, 0);
    step();
    chk("e_grant_after", grant_o, ARB_IDLE);
    clear_inputs();

`ifdef ARB_ROUND_ROBIN_EN
    // Continuous reads from both masters alternate once M0 has been served.
    begin
      logic [1:0] exp_seq[8];
      exp_seq[0] = ARB_IDLE;  exp_seq[1] = ARB_M1_RD;
      exp_seq[2] = ARB_IDLE;  exp_seq[3] = ARB_M0_RD;
      exp_seq[4] = ARB_IDLE;  exp_seq[5] = ARB_M1_RD;
      exp_seq[6] = ARB_IDLE;  exp_seq[7] = ARB_M0_RD;
      do_reset();
      s_if.ar_ready = 1'b1; s_if.r_valid = 1'b1;
      m0_if.r_ready = 1'b1; m1_if.r_ready = 1'b1;
      m0_if.ar_valid = 1'b1;
      step();
      chk("f_first_m0", grant_o, ARB_M0_RD);
      m1_if.ar_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
        step();
        chk($sformatf("f_rr_%0d", k), grant_o, exp_seq[k]);
      end
      clear_inputs();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
